// File: rtl/o9_ctrl_pkg.sv
// Shared types for the O9 multicycle control unit: opcodes, FSM states,
// datapath select encodings and the per-state control word.
package o9_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_FETCH_WAIT = 4'd1,
        S_DECODE     = 4'd2,
        S_LW_ADDR    = 4'd3,
        S_LW_WB      = 4'd4,
        S_SW         = 4'd5,
        S_R_EXEC     = 4'd6,
        S_R_WB       = 4'd7,
        S_I_EXEC     = 4'd8,
        S_I_WB       = 4'd9,
        S_BRANCH     = 4'd10,
        S_JUMP       = 4'd11,
        S_TRAP       = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_RSVD  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        SRCB_B       = 2'b00,
        SRCB_ONE     = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } src_b_e;

    typedef struct packed {
        logic    pc_write_cond;
        logic    pc_write;
        logic    iord;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    ir_write;
        pc_src_e pc_source;
        alu_op_e alu_op;
        src_b_e  alu_src_b;
        logic    alu_src_a;
        logic    reg_write;
        logic    reg_dst;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and the O9 datapath.
interface multicycle_control_if;

    logic [5:0] opCode;
    logic       PCWriteCond;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;

    modport master (
        input  opCode,
        output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
        output IRWrite, PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst
    );

    modport slave (
        output opCode,
        input  PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
        input  IRWrite, PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst
    );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Moore output decode: current FSM state to datapath control word.
module multicycle_ctrl_decode
    import o9_ctrl_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
            end
            S_FETCH_WAIT: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_LW_ADDR, S_LW_WB: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_IMM;
                ctrl.iord       = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = (state == S_LW_WB);
                ctrl.reg_write  = (state == S_LW_WB);
            end
            S_SW: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_R_EXEC, S_R_WB: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
                ctrl.reg_dst   = (state == S_R_WB);
                ctrl.reg_write = (state == S_R_WB);
            end
            S_I_EXEC, S_I_WB: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.reg_write = (state == S_I_WB);
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_source     = PC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_source = PC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// O9 multicycle control FSM: sequences fetch/decode/execute/memory/write-back,
// flags illegal opcodes and counts retired instructions.
module multicycle_control
    import o9_ctrl_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus,
    output logic                 illegal,
    output logic [CNT_W-1:0]     retired,
    output logic [3:0]           state_dbg
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e state;
    state_e state_nx;
    ctrl_t  ctrl;
    logic   retire;

    multicycle_ctrl_decode u_decode (
        .state (state),
        .ctrl  (ctrl)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            state <= state_nx;
            if (state_nx == S_TRAP)
                illegal <= 1'b1;
            if (retire)
                retired <= retired + CNT_ONE;
        end
    end

    always_comb begin
        state_nx = S_FETCH;
        retire   = 1'b0;
        case (state)
            S_FETCH:      state_nx = S_FETCH_WAIT;
            S_FETCH_WAIT: state_nx = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    (bus.opCode == OP_R):    state_nx = S_R_EXEC;
                    (bus.opCode == OP_LW):   state_nx = S_LW_ADDR;
                    (bus.opCode == OP_SW):   state_nx = S_SW;
                    (bus.opCode == OP_BEQ):  state_nx = S_BRANCH;
                    (bus.opCode == OP_ADDI): state_nx = S_I_EXEC;
                    (bus.opCode == OP_J):    state_nx = S_JUMP;
                    default:                 state_nx = S_TRAP;
                endcase
            end
            S_LW_ADDR: state_nx = S_LW_WB;
            S_R_EXEC:  state_nx = S_R_WB;
            S_I_EXEC:  state_nx = S_I_WB;
            S_LW_WB, S_SW, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                retire = 1'b1;
            end
            S_TRAP: begin
                // A non-halting trap retires the bad opcode as a NOP
                if (HALT_ON_ILLEGAL)
                    state_nx = S_TRAP;
                else
                    retire = 1'b1;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    assign bus.PCWriteCond = ctrl.pc_write_cond & ~reset;
    assign bus.PCWrite     = ctrl.pc_write & ~reset;
    assign bus.IorD        = ctrl.iord;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write & ~reset;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.IRWrite     = ctrl.ir_write & ~reset;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.RegWrite    = ctrl.reg_write & ~reset;
    assign bus.RegDst      = ctrl.reg_dst;
    assign state_dbg       = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: halting 16-bit instance and
// non-halting 4-bit instance against an instruction-level model.
module tb_multicycle_control;
    import o9_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, reset_b;
    logic        illegal_a, illegal_b;
    logic [15:0] retired_a;
    logic [3:0]  retired_b;
    logic [3:0]  state_a, state_b;
    logic [15:0] ctl_a, ctl_b;

    multicycle_control_if bus_a ();
    multicycle_control_if bus_b ();

    multicycle_control #(.HALT_ON_ILLEGAL(1'b1), .CNT_W(16)) dut_a (
        .clk       (clk),
        .reset     (reset_a),
        .bus       (bus_a.master),
        .illegal   (illegal_a),
        .retired   (retired_a),
        .state_dbg (state_a)
    );

    multicycle_control #(.HALT_ON_ILLEGAL(1'b0), .CNT_W(4)) dut_b (
        .clk       (clk),
        .reset     (reset_b),
        .bus       (bus_b.master),
        .illegal   (illegal_b),
        .retired   (retired_b),
        .state_dbg (state_b)
    );

    assign ctl_a = {bus_a.PCWriteCond, bus_a.PCWrite, bus_a.IorD,
                    bus_a.MemRead, bus_a.MemWrite, bus_a.MemtoReg,
                    bus_a.IRWrite, bus_a.PCSource, bus_a.ALUOp,
                    bus_a.ALUSrcB, bus_a.ALUSrcA, bus_a.RegWrite,
                    bus_a.RegDst};
    assign ctl_b = {bus_b.PCWriteCond, bus_b.PCWrite, bus_b.IorD,
                    bus_b.MemRead, bus_b.MemWrite, bus_b.MemtoReg,
                    bus_b.IRWrite, bus_b.PCSource, bus_b.ALUOp,
                    bus_b.ALUSrcB, bus_b.ALUSrcA, bus_b.RegWrite,
                    bus_b.RegDst};

    int total = 0;
    int bad = 0;
    int sel = 0;
    int exp_ret = 0;
    bit exp_ill = 1'b0;
    logic [5:0] legal_ops [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Control word from the per-state output table, writes gated by reset
    function automatic logic [15:0] exp_ctrl(input state_e s, input logic rst);
        logic pwc, pw, iord, mr, mw, m2r, irw, sa, rw, rd;
        logic [1:0] pcs, aop, sb;
        {pwc, pw, iord, mr, mw, m2r, irw, sa, rw, rd} = '0;
        pcs = 2'b00; aop = 2'b00; sb = 2'b00;
        case (s)
            S_FETCH:      mr = 1'b1;
            S_FETCH_WAIT: begin mr = 1; irw = 1; sb = 2'b01; pw = 1; end
            S_DECODE:     sb = 2'b10;
            S_LW_ADDR:    begin sa = 1; sb = 2'b10; iord = 1; mr = 1; end
            S_LW_WB: begin
                sa = 1; sb = 2'b10; iord = 1; mr = 1; m2r = 1; rw = 1;
            end
            S_SW:         begin sa = 1; sb = 2'b10; iord = 1; mw = 1; end
            S_R_EXEC:     begin sa = 1; aop = 2'b10; end
            S_R_WB:       begin sa = 1; aop = 2'b10; rd = 1; rw = 1; end
            S_I_EXEC:     begin sa = 1; sb = 2'b10; end
            S_I_WB:       begin sa = 1; sb = 2'b10; rw = 1; end
            S_BRANCH:     begin sa = 1; aop = 2'b01; pcs = 2'b01; pwc = 1; end
            S_JUMP:       begin pcs = 2'b10; pw = 1; end
            default: ;
        endcase
        if (rst) {pwc, pw, mw, irw, rw} = '0;
        return {pwc, pw, iord, mr, mw, m2r, irw, pcs, aop, sb, sa, rw, rd};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Check the current cycle against the expected state, then advance one clock
    task automatic step(input state_e s);
        logic rst;
        logic [31:0] m;
        rst = (sel != 0) ? reset_b : reset_a;
        m = (sel != 0) ? 32'hF : 32'hFFFF;
        chk($sformatf("state_%s", s.name()),
            (sel != 0) ? state_b : state_a, s);
        chk($sformatf("ctrl_%s", s.name()),
            (sel != 0) ? ctl_b : ctl_a, exp_ctrl(s, rst));
        chk("illegal", (sel != 0) ? illegal_b : illegal_a, exp_ill);
        chk("retired", (sel != 0) ? retired_b : retired_a, exp_ret & m);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        if (sel != 0) reset_b = 1'b1; else reset_a = 1'b1;
        @(posedge clk); #1;
        exp_ret = 0;
        exp_ill = 1'b0;
        step(S_FETCH);
        if (sel != 0) reset_b = 1'b0; else reset_a = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] op);
        state_e q[$];
        if (sel != 0) bus_b.opCode = op; else bus_a.opCode = op;
        q = '{S_FETCH, S_FETCH_WAIT, S_DECODE};
        case (op)
            OP_R:    begin q.push_back(S_R_EXEC); q.push_back(S_R_WB); end
            OP_LW:   begin q.push_back(S_LW_ADDR); q.push_back(S_LW_WB); end
            OP_SW:   q.push_back(S_SW);
            OP_BEQ:  q.push_back(S_BRANCH);
            OP_ADDI: begin q.push_back(S_I_EXEC); q.push_back(S_I_WB); end
            OP_J:    q.push_back(S_JUMP);
            default: q.push_back(S_TRAP);
        endcase
        foreach (q[i]) begin
            if (q[i] == S_TRAP) exp_ill = 1'b1;
            step(q[i]);
        end
        if (q[$] == S_TRAP && sel == 0)
            repeat (19) step(S_TRAP);
        else
            exp_ret++;
    endtask

    function automatic logic [5:0] rand_legal();
        return legal_ops[$urandom_range(0, 5)];
    endfunction

    function automatic logic [5:0] rand_illegal();
        logic [5:0] op;
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
        return op;
    endfunction

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        bus_a.opCode = 6'd0;
        bus_b.opCode = 6'd0;

        sel = 0;
        pulse_reset();
        run_instr(OP_R);
        run_instr(OP_LW);
        run_instr(OP_SW);
        run_instr(OP_BEQ);
        run_instr(OP_J);
        run_instr(OP_ADDI);
        repeat (30) run_instr(rand_legal());
        run_instr(6'b111111);
        pulse_reset();
        run_instr(OP_J);

        bus_a.opCode = OP_LW;
        step(S_FETCH);
        step(S_FETCH_WAIT);
        step(S_DECODE);
        step(S_LW_ADDR);
        chk("lw_wb_state", state_a, S_LW_WB);
        chk("lw_wb_regwrite", bus_a.RegWrite, 1'b1);
        reset_a = 1'b1;
        #1;
        chk("rst_regwrite_comb", bus_a.RegWrite, 1'b0);
        @(posedge clk); #1;
        exp_ret = 0;
        exp_ill = 1'b0;
        chk("rst_regwrite_edge", bus_a.RegWrite, 1'b0);
        step(S_FETCH);
        reset_a = 1'b0;
        run_instr(OP_R);

        reset_a = 1'b1;
        sel = 1;
        pulse_reset();
        repeat (16) run_instr(rand_legal());
        chk("retired_wrap", retired_b, 4'd0);
        run_instr(6'b111111);
        run_instr(OP_LW);
        repeat (40) begin
            if ($urandom_range(0, 6) == 0)
                run_instr(rand_illegal());
            else
                run_instr(rand_legal());
        end
        pulse_reset();
        run_instr(OP_SW);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control FSM for the O9 processor. It is the consumer of the datapath's opCode output and the producer of every datapath control input.
- Sequences fetch, decode, execute, memory and write-back per instruction.
- Memory is word-addressed RAM with one-cycle synchronous read. The PC advances by 1 per instruction.
- Flags unsupported opcodes and counts retired instructions.

Parameters:
- HALT_ON_ILLEGAL, 1, 1: stay in S_TRAP after an illegal opcode. 0: treat it as a NOP and return to S_FETCH.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- opCode  in  6  IR[31:26] from the datapath; valid from S_DECODE onward
- PCWriteCond  out  1  branch-conditional PC write
- PCWrite  out  1  unconditional PC write
- IorD  out  1  memory address select: 0=PC, 1=ALU bus
- MemRead  out  1  memory read strobe
- MemWrite  out  1  RAM wren
- MemtoReg  out  1  write-back data: 0=ALU bus, 1=memory
- IRWrite  out  1  latch instruction register
- PCSource  out  2  00=ALU bus, 01=ALU register, 10=26-bit sign-extended jump target
- ALUOp  out  2  00=add, 01=sub, 10=funct field, 11 reserved. The datapath ALU_Decoder input widens to 2 bits in the same change.
- ALUSrcB  out  2  00=B, 01=const 1, 10=sign-ext imm, 11=sign-ext imm<<2
- ALUSrcA  out  1  0=PC, 1=A
- RegWrite  out  1  register-file write
- RegDst  out  1  write register select: 0=rt, 1=rd
- illegal  out  1  sticky illegal-opcode flag
- retired  out  CNT_W  retired-instruction count
- state_dbg  out  4  current state encoding

Behaviour:
- Reset:
  - At a clk edge with reset=1: state<=S_FETCH, illegal<=0, retired<=0.
  - While reset=1, PCWrite, PCWriteCond, IRWrite, RegWrite and MemWrite are forced to 0 combinationally.
  - Reset mid-instruction abandons the instruction; no partial write occurs after the reset edge.
- Output style: Moore outputs decoded from the state register. Any signal not listed for a state is 0 (all selects 0).
- Opcodes:
  - R=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010.
  - Any other value is illegal.
- States and outputs:
  - S_FETCH: IorD=0, MemRead=1. Next: S_FETCH_WAIT.
  - S_FETCH_WAIT: MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1 (PC<=PC+1). Next: S_DECODE.
  - S_DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00; the ALU register captures the branch target PC+1+imm. Next state by opCode: R->S_R_EXEC, LW->S_LW_ADDR, SW->S_SW, BEQ->S_BRANCH, ADDI->S_I_EXEC, J->S_JUMP, else S_TRAP.
  - S_LW_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, IorD=1, MemRead=1. Next: S_LW_WB.
  - S_LW_WB: same ALU selects, IorD and MemRead as S_LW_ADDR, plus MemtoReg=1, RegDst=0, RegWrite=1. Retire. Next: S_FETCH.
  - S_SW: ALUSrcA=1, ALUSrcB=10, ALUOp=00, IorD=1, MemWrite=1. Retire. Next: S_FETCH.
  - S_R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: S_R_WB.
  - S_R_WB: same ALU selects as S_R_EXEC, plus RegDst=1, MemtoReg=0, RegWrite=1. Retire. Next: S_FETCH.
  - S_I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: S_I_WB.
  - S_I_WB: same ALU selects as S_I_EXEC, plus RegDst=0, RegWrite=1. Retire. Next: S_FETCH.
  - S_BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1. Retire. Next: S_FETCH.
  - S_JUMP: PCSource=10, PCWrite=1. Retire. Next: S_FETCH.
  - S_TRAP: illegal<=1 on entry, all writes 0. Stays in S_TRAP if HALT_ON_ILLEGAL=1; otherwise goes to S_FETCH with retired incremented.
- Latency in cycles: LW 5, SW 4, R 5, ADDI 5, BEQ 4, J 4.
- retired increments by 1 on the last state of each instruction and wraps modulo 2^CNT_W.
- Unused state encodings transition to S_FETCH with all outputs 0.

Decomposition:
- Package o9_ctrl_pkg holds:
  - opcode constants;
  - the state enum (4-bit);
  - ALUOp, PCSource and ALUSrcB encodings;
  - a control-word struct.
- One sub-module, multicycle_ctrl_decode: combinational state -> control word. The top module holds the state register, the next-state logic, illegal and retired.

Test Plan:
- Reset 2 cycles then release:
  - state_dbg=S_FETCH, MemRead=1, all write enables 0;
  - the next cycle has IRWrite=1, PCWrite=1, ALUSrcB=01.
- opCode=000000 at S_DECODE -> S_R_EXEC then S_R_WB with RegDst=1, RegWrite=1, ALUOp=10; 5 cycles total; retired 0->1.
- opCode=100011 -> S_LW_ADDR (IorD=1, MemRead=1) then S_LW_WB (MemtoReg=1, RegWrite=1); SW (101011) asserts MemWrite=1 for exactly 1 cycle; 4 cycles total.
- opCode=000100 -> S_BRANCH with ALUOp=01, PCSource=01, PCWriteCond=1, PCWrite=0; opCode=000010 -> PCSource=10, PCWrite=1; each 4 cycles.
- opCode=111111 with HALT_ON_ILLEGAL=1 -> illegal=1 and S_TRAP held for 20 cycles; a reset pulse clears illegal and returns to S_FETCH. Repeat with HALT_ON_ILLEGAL=0: illegal=1 and fetch resumes.
- Assert reset during S_LW_WB -> no RegWrite after that edge, state=S_FETCH; with CNT_W=4, 16 retirements wrap retired to 0.
